// File: rtl/pha_pkg.sv
// Shared types for the pulse height analyzer: FSM state encoding and the result record.
// The record mirrors one delivered result (height, width, sat, pileup) at the default widths.
// Optional feature macro used by this block: PHA_PILEUP_EN (pile-up detection).
package pha_pkg;

  localparam int PHA_DATA_W  = 14;
  localparam int PHA_WIDTH_W = 10;

  typedef enum logic [0:0] {
    PHA_IDLE  = 1'b0,
    PHA_PULSE = 1'b1
  } pha_state_e;

  typedef struct packed {
    logic [PHA_DATA_W-1:0]  height;
    logic [PHA_WIDTH_W-1:0] width;
    logic                   sat;
    logic                   pileup;
  } pha_result_t;

endpackage

// File: rtl/pulse_height_analyzer_if.sv
// Result handshake bundle between the analyzer and the histogram/readout logic.
// master (analyzer): drives out_valid and the result fields, samples out_ready.
// slave (consumer): drives out_ready; fields are stable while out_valid && !out_ready.
interface pulse_height_analyzer_if #(
  parameter int DATA_W  = 14,
  parameter int WIDTH_W = 10
);

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  pulse_height;
  logic [WIDTH_W-1:0] pulse_width;
  logic               pulse_sat;
  logic               pulse_pileup;

  modport master (
    output out_valid, pulse_height, pulse_width, pulse_sat, pulse_pileup,
    input  out_ready
  );

  modport slave (
    input  out_valid, pulse_height, pulse_width, pulse_sat, pulse_pileup,
    output out_ready
  );

endinterface

// File: rtl/pha_peak_track.sv
// Per-pulse tracker: peak sample, saturating width, saturation flag and optional pile-up flag.
// Ports: clk_i/rst_i; start_i loads the first sample, advance_i folds in a continuing sample;
// peak_o/width_o/sat_o/pileup_o hold the running values (registered, one cycle after the strobe).
// Pile-up tracking is built only when PHA_PILEUP_EN is defined; otherwise pileup_o is 0.
module pha_peak_track #(
  parameter int DATA_W  = 14,
  parameter int WIDTH_W = 10
`ifdef PHA_PILEUP_EN
  ,
  parameter int HYST    = 16
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               advance_i,
  input  logic [DATA_W-1:0]  sample_i,
  output logic [DATA_W-1:0]  peak_o,
  output logic [WIDTH_W-1:0] width_o,
  output logic               sat_o,
  output logic               pileup_o
);

  localparam logic [WIDTH_W-1:0] W_MAX = '1;

  logic [DATA_W-1:0]  peak_q, peak_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               sat_q, sat_d;

  always_comb begin
    peak_d  = peak_q;
    width_d = width_q;
    sat_d   = sat_q;
    if (start_i) begin
      peak_d  = sample_i;
      width_d = WIDTH_W'(1);
      sat_d   = 1'b0;
    end else if (advance_i) begin
      if (sample_i > peak_q) peak_d = sample_i;
      if (width_q != W_MAX) begin
        width_d = width_q + 1'b1;
        if (width_q == W_MAX - 1'b1) sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_q  <= '0;
      width_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      peak_q  <= peak_d;
      width_q <= width_d;
      sat_q   <= sat_d;
    end
  end

  assign peak_o  = peak_q;
  assign width_o = width_q;
  assign sat_o   = sat_q;

`ifdef PHA_PILEUP_EN
  // Compares are done one bit wider so "x + HYST" never wraps and
  // "peak - HYST" needs no floor.
  localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

  logic              falling_q, falling_d;
  logic              pile_q, pile_d;
  logic [DATA_W-1:0] min_q, min_d;

  always_comb begin
    falling_d = falling_q;
    pile_d    = pile_q;
    min_d     = min_q;
    if (start_i) begin
      falling_d = 1'b0;
      pile_d    = 1'b0;
      min_d     = sample_i;
    end else if (advance_i) begin
      // The valley minimum restarts at the first dip and only decreases after.
      if (!falling_q || sample_i < min_q) min_d = sample_i;
      if ({1'b0, sample_i} + HYST_X < {1'b0, peak_q}) falling_d = 1'b1;
      if (falling_q && ({1'b0, sample_i} > {1'b0, min_q} + HYST_X)) pile_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      falling_q <= 1'b0;
      pile_q    <= 1'b0;
      min_q     <= '0;
    end else begin
      falling_q <= falling_d;
      pile_q    <= pile_d;
      min_q     <= min_d;
    end
  end

  assign pileup_o = pile_q;
`else
  assign pileup_o = 1'b0;
`endif

endmodule

// File: rtl/pulse_height_analyzer.sv
// Pulse height analyzer: threshold trigger with hysteresis, runt rejection, one-deep result slot.
// Ports: CLOCK_65/rst, ad_data sample stream, thresh (latched in IDLE), drop_cnt, and the
// result handshake (master modport). Result loads on the edge that sees the ending sample.
// Optional macro PHA_PILEUP_EN enables pile-up detection in the tracker.
module pulse_height_analyzer
  import pha_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int HYST      = 16,
  parameter int MIN_WIDTH = 3,
  parameter int WIDTH_W   = 10,
  parameter int CNT_W     = 16
) (
  input  logic                     CLOCK_65,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        ad_data,
  input  logic [DATA_W-1:0]        thresh,
  output logic [CNT_W-1:0]         drop_cnt,
  pulse_height_analyzer_if.master  res
);

  localparam logic [DATA_W-1:0]  HYST_V  = DATA_W'(HYST);
  localparam logic [WIDTH_W-1:0] MIN_W_V = WIDTH_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  pha_state_e         state_q, state_d;
  logic [DATA_W-1:0]  thr_q, thr_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  height_q, height_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               sat_q, sat_d;
  logic               pile_q, pile_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               start, advance, pulse_end;
  logic [DATA_W-1:0]  lo;
  logic [DATA_W-1:0]  trk_peak;
  logic [WIDTH_W-1:0] trk_width;
  logic               trk_sat, trk_pile;
  logic               accept, slot_free;

  // Pulse end level, floored at zero for small thresholds.
  assign lo = (thr_q >= HYST_V) ? (thr_q - HYST_V) : '0;

  pha_peak_track #(
    .DATA_W  (DATA_W),
    .WIDTH_W (WIDTH_W)
`ifdef PHA_PILEUP_EN
    ,
    .HYST    (HYST)
`endif
  ) u_track (
    .clk_i     (CLOCK_65),
    .rst_i     (rst),
    .start_i   (start),
    .advance_i (advance),
    .sample_i  (ad_data),
    .peak_o    (trk_peak),
    .width_o   (trk_width),
    .sat_o     (trk_sat),
    .pileup_o  (trk_pile)
  );

  // FSM next state and strobes. thr_q follows thresh on every IDLE cycle,
  // including the trigger edge, and is frozen for the rest of the pulse.
  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    start     = 1'b0;
    advance   = 1'b0;
    pulse_end = 1'b0;
    unique case (state_q)
      PHA_IDLE: begin
        thr_d = thresh;
        if (ad_data > thr_q) begin
          state_d = PHA_PULSE;
          start   = 1'b1;
        end
      end
      PHA_PULSE: begin
        if (ad_data > lo) begin
          advance = 1'b1;
        end else begin
          pulse_end = 1'b1;
          state_d   = PHA_IDLE;
        end
      end
      default: state_d = PHA_IDLE;
    endcase
  end

  // Output slot: the tracker still holds the pulse totals on the ending cycle
  // because the ending sample is never folded in.
  assign accept    = pulse_end && (trk_width >= MIN_W_V);
  assign slot_free = !valid_q || res.out_ready;

  always_comb begin
    valid_d  = valid_q;
    height_d = height_q;
    width_d  = width_q;
    sat_d    = sat_q;
    pile_d   = pile_q;
    drop_d   = drop_q;
    if (valid_q && res.out_ready) valid_d = 1'b0;
    if (accept) begin
      if (slot_free) begin
        valid_d  = 1'b1;
        height_d = trk_peak;
        width_d  = trk_width;
        sat_d    = trk_sat;
        pile_d   = trk_pile;
      end else if (drop_q != CNT_MAX) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_65 or posedge rst) begin
    if (rst) begin
      state_q  <= PHA_IDLE;
      thr_q    <= '0;
      valid_q  <= 1'b0;
      height_q <= '0;
      width_q  <= '0;
      sat_q    <= 1'b0;
      pile_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      valid_q  <= valid_d;
      height_q <= height_d;
      width_q  <= width_d;
      sat_q    <= sat_d;
      pile_q   <= pile_d;
      drop_q   <= drop_d;
    end
  end

  assign res.out_valid    = valid_q;
  assign res.pulse_height = height_q;
  assign res.pulse_width  = width_q;
  assign res.pulse_sat    = sat_q;
  assign res.pulse_pileup = pile_q;
  assign drop_cnt         = drop_q;

endmodule
